// File: rtl/c11_pkg.sv
// Shared constants and combinational helpers for the Fritz C11 evaluator:
// the boolean function itself and a 3-input majority voter.
package c11_pkg;

    localparam int IN_W  = 10;

    localparam int G1_B  = 0;
    localparam int G2_B  = 1;
    localparam int G3_B  = 2;
    localparam int G4_B  = 3;
    localparam int G5_B  = 4;
    localparam int G6_B  = 5;
    localparam int G7_B  = 6;
    localparam int G8_B  = 7;
    localparam int G9_B  = 8;
    localparam int G10_B = 9;

    function automatic logic c11_eval(input logic [IN_W-1:0] g);
        logic t7;
        logic t8;
        logic t9;
        t7 = g[G1_B] & g[G2_B] & g[G3_B] & (g[G6_B] ^ g[G7_B]) & ~(g[G4_B] & g[G5_B]);
        t8 = g[G8_B] & g[G9_B];
        t9 = g[G9_B] & g[G10_B];
        return g[G10_B] & ~(t7 | t8 | t9);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/c11_lane.sv
// One evaluation lane: three redundant copies with per-copy fault injection
// and a majority voter, or a single bare copy when TMR is disabled.
module c11_lane
    import c11_pkg::*;
#(
    parameter int TMR = 1
) (
    input  logic [IN_W-1:0] g,
    input  logic            inj,
    input  logic [1:0]      inj_copy,
    output logic            y,
    output logic            mismatch
);

    generate
        if (TMR != 0) begin : g_tmr
            logic y0;
            logic y1;
            logic y2;

            // inj_copy==3 matches no copy, so it means "no injection"
            assign y0 = c11_eval(g) ^ (inj && (inj_copy == 2'd0));
            assign y1 = c11_eval(g) ^ (inj && (inj_copy == 2'd1));
            assign y2 = c11_eval(g) ^ (inj && (inj_copy == 2'd2));

            assign y        = maj3(y0, y1, y2);
            assign mismatch = ~((y0 & y1 & y2) | ~(y0 | y1 | y2));
        end else begin : g_single
            logic unused_inj;

            assign unused_inj = ^{inj, inj_copy};
            assign y          = c11_eval(g);
            assign mismatch   = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/c11_fritz_pipe.sv
// Multi-lane pipelined Fritz C11 evaluator with optional TMR voting,
// valid/ready flow control and a saturating mismatch counter.
module c11_fritz_pipe
    import c11_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int TMR    = 1,
    parameter int CNT_W  = 8,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W*LANES-1:0] in_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_vec,
    output logic [LANES-1:0]      mismatch,
    output logic [CNT_W-1:0]      err_cnt,
    input  logic                  cnt_clr,
    input  logic                  inj_en,
    input  logic [LANE_W-1:0]     inj_lane,
    input  logic [1:0]            inj_copy
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [IN_W*LANES-1:0] vec_ev;
    logic                  vld_ev;
    logic                  inj_en_ev;
    logic [LANE_W-1:0]     inj_lane_ev;
    logic [1:0]            inj_copy_ev;
    logic [LANES-1:0]      y_ev;
    logic [LANES-1:0]      mm_ev;

    logic                  adv_p2;
    logic                  vld_p2;
    logic [LANES-1:0]      out_vec_p2;
    logic [LANES-1:0]      mismatch_p2;
    logic [CNT_W-1:0]      cnt;

    assign adv_p2 = ~vld_p2 | out_ready;

    generate
        if (STAGES >= 2) begin : g_s2
            logic                  vld_p1;
            logic                  adv_p1;
            logic [IN_W*LANES-1:0] vec_p1;
            logic                  inj_en_p1;
            logic [LANE_W-1:0]     inj_lane_p1;
            logic [1:0]            inj_copy_p1;

            assign adv_p1   = ~vld_p1 | adv_p2;
            assign in_ready = adv_p1;

            // ---- stage 1: input beat and injection controls ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1 <= 1'b0;
                end else if (adv_p1) begin
                    vld_p1 <= in_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (adv_p1 && in_valid) begin
                    vec_p1      <= in_vec;
                    inj_en_p1   <= inj_en;
                    inj_lane_p1 <= inj_lane;
                    inj_copy_p1 <= inj_copy;
                end
            end

            assign vld_ev      = vld_p1;
            assign vec_ev      = vec_p1;
            assign inj_en_ev   = inj_en_p1;
            assign inj_lane_ev = inj_lane_p1;
            assign inj_copy_ev = inj_copy_p1;
        end else begin : g_s1
            assign in_ready    = adv_p2;
            assign vld_ev      = in_valid;
            assign vec_ev      = in_vec;
            assign inj_en_ev   = inj_en;
            assign inj_lane_ev = inj_lane;
            assign inj_copy_ev = inj_copy;
        end
    endgenerate

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            c11_lane #(
                .TMR(TMR)
            ) u_lane (
                .g        (vec_ev[IN_W*k +: IN_W]),
                .inj      (inj_en_ev && (inj_lane_ev == LANE_W'(k))),
                .inj_copy (inj_copy_ev),
                .y        (y_ev[k]),
                .mismatch (mm_ev[k])
            );
        end
    endgenerate

    // ---- stage 2: voted result and mismatch ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            out_vec_p2  <= '0;
            mismatch_p2 <= '0;
        end else if (adv_p2) begin
            vld_p2 <= vld_ev;
            if (vld_ev) begin
                out_vec_p2  <= y_ev;
                mismatch_p2 <= mm_ev;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (vld_p2 && out_ready && (|mismatch_p2)) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign out_valid = vld_p2;
    assign out_vec   = out_vec_p2;
    assign mismatch  = mismatch_p2;
    assign err_cnt   = cnt;

endmodule
